mem_port_arbiter: RTL and testbench

- Arbitrates one single-port instruction/data memory between the fetch stage (IF) and the load/store stage (DM) of the STRV32I core.
- Latches the granted command, drives the memory handshake, returns read data with a one-cycle ack, and raises a pipeline stall while any request is outstanding.
- Sits between the fetch/LSU logic and the memory wrapper.
- Takes a fetch-flush input from the core control unit so that fetches on a squashed path are discarded.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (IF) and load/store (DM).
// Define ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES cycles without mem_ready_in.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    if_req_in,
  input  logic [ADDR_WIDTH-1:0]   if_addr_in,
  input  logic                    if_flush_in,
  output logic [DATA_WIDTH-1:0]   if_rdata_out,
  output logic                    if_ack_out,
  input  logic                    dm_req_in,
  input  logic                    dm_we_in,
  input  logic [DATA_WIDTH/8-1:0] dm_wmask_in,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_in,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_in,
  output logic [DATA_WIDTH-1:0]   dm_rdata_out,
  output logic                    dm_ack_out,
  output logic                    err_out,
  output logic                    mem_req_out,
  output logic                    mem_we_out,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_wdata_out,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
  input  logic                    mem_ready_in,
  output logic                    stall_out
);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, ACK} state_t;
  typedef enum logic {GNT_IF, GNT_DM} grant_t;

  state_t state;
  grant_t last_grant;
  logic   if_discard;
  logic   if_live;
  logic   grant_if;
  logic   grant_dm;
  logic   drop_fetch;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    if_live    = if_req_in & ~if_flush_in;
    grant_dm   = dm_req_in & (~if_live | (last_grant == GNT_IF));
    grant_if   = if_live & ~grant_dm;
    drop_fetch = if_discard | if_flush_in;
  end

  assign stall_out = (if_req_in & ~if_ack_out & ~if_flush_in) | (dm_req_in & ~dm_ack_out);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      last_grant    <= GNT_IF;
      if_discard    <= 1'b0;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_wmask_out <= '0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      if_rdata_out  <= '0;
      if_ack_out    <= 1'b0;
      dm_rdata_out  <= '0;
      dm_ack_out    <= 1'b0;
      err_out       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      if_ack_out <= 1'b0;
      dm_ack_out <= 1'b0;
      err_out    <= 1'b0;
      case (state)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (grant_dm) begin
            mem_req_out   <= 1'b1;
            mem_we_out    <= dm_we_in;
            mem_wmask_out <= dm_wmask_in;
            mem_addr_out  <= dm_addr_in;
            mem_wdata_out <= dm_wdata_in;
            last_grant    <= GNT_DM;
            state         <= DM_ACC;
          end else if (grant_if) begin
            mem_req_out   <= 1'b1;
            mem_we_out    <= 1'b0;
            mem_wmask_out <= '0;
            mem_addr_out  <= if_addr_in;
            mem_wdata_out <= '0;
            last_grant    <= GNT_IF;
            if_discard    <= 1'b0;
            state         <= IF_ACC;
          end
        end
        IF_ACC, DM_ACC: begin
          if (state == IF_ACC && if_flush_in)
            if_discard <= 1'b1;
          // A flushed fetch still finishes on the bus but its ack and data are dropped.
          if (mem_ready_in) begin
            mem_req_out <= 1'b0;
            state       <= ACK;
            if (state == DM_ACC) begin
              dm_rdata_out <= mem_rdata_in;
              dm_ack_out   <= 1'b1;
            end else if (!drop_fetch) begin
              if_rdata_out <= mem_rdata_in;
              if_ack_out   <= 1'b1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            mem_req_out <= 1'b0;
            state       <= ACK;
            if (state == DM_ACC) begin
              dm_rdata_out <= '0;
              dm_ack_out   <= 1'b1;
              err_out      <= 1'b1;
            end else if (!drop_fetch) begin
              if_rdata_out <= '0;
              if_ack_out   <= 1'b1;
              err_out      <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter; one table row per clock cycle.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_flush_in;
  logic [31:0] if_rdata_out;
  logic        if_ack_out;
  logic        dm_req_in;
  logic        dm_we_in;
  logic [3:0]  dm_wmask_in;
  logic [31:0] dm_addr_in;
  logic [31:0] dm_wdata_in;
  logic [31:0] dm_rdata_out;
  logic        dm_ack_out;
  logic        err_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [3:0]  mem_wmask_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in;
  logic        mem_ready_in;
  logic        stall_out;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_flush_in(if_flush_in),
    .if_rdata_out(if_rdata_out), .if_ack_out(if_ack_out),
    .dm_req_in(dm_req_in), .dm_we_in(dm_we_in), .dm_wmask_in(dm_wmask_in),
    .dm_addr_in(dm_addr_in), .dm_wdata_in(dm_wdata_in),
    .dm_rdata_out(dm_rdata_out), .dm_ack_out(dm_ack_out), .err_out(err_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_wmask_out(mem_wmask_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in), .mem_ready_in(mem_ready_in), .stall_out(stall_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic rst, ifr; logic [31:0] ia; logic fl;
    logic dmr, we; logic [3:0] wm; logic [31:0] da, wd;
    logic rdy; logic [31:0] rd;
    logic e_mreq, e_mwe; logic [3:0] e_mwm; logic [31:0] e_maddr, e_mwd;
    logic e_iack; logic [31:0] e_ird; logic e_dack; logic [31:0] e_drd;
    logic e_stall, chk_i, chk_d;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, ifr, input logic [31:0] ia, input logic fl,
                     input logic dmr, we, input logic [3:0] wm, input logic [31:0] da, wd,
                     input logic rdy, input logic [31:0] rd,
                     input logic mreq, mwe, input logic [3:0] mwm, input logic [31:0] maddr, mwd,
                     input logic iack, input logic [31:0] ird, input logic dack, input logic [31:0] drd,
                     input logic stall, ci, cd);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.ia = ia; v.fl = fl;
    v.dmr = dmr; v.we = we; v.wm = wm; v.da = da; v.wd = wd;
    v.rdy = rdy; v.rd = rd;
    v.e_mreq = mreq; v.e_mwe = mwe; v.e_mwm = mwm; v.e_maddr = maddr; v.e_mwd = mwd;
    v.e_iack = iack; v.e_ird = ird; v.e_dack = dack; v.e_drd = drd;
    v.e_stall = stall; v.chk_i = ci; v.chk_d = cd;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    rst_in = 1'b0; if_req_in = 1'b0; if_addr_in = '0; if_flush_in = 1'b0;
    dm_req_in = 1'b0; dm_we_in = 1'b0; dm_wmask_in = '0; dm_addr_in = '0; dm_wdata_in = '0;
    mem_ready_in = 1'b0; mem_rdata_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got;

    // rst ifr ia fl | dmr we wm da wd | rdy rd || mreq mwe mwm maddr mwd | iack ird | dack drd | stall ci cd
    // single fetch, zero wait states
    add(0,1,'h100,0, 0,0,0,0,0, 1,'h13, 0,0,0,0,0, 0,0, 0,0, 1, 1,1);
    add(0,1,'h100,0, 0,0,0,0,0, 1,'h13, 1,0,0,'h100,0, 0,0, 0,0, 1, 1,1);
    add(0,1,'h100,0, 0,0,0,0,0, 1,'h13, 0,0,0,0,0, 1,'h13, 0,0, 0, 1,1);
    add(0,0,0,0, 0,0,0,0,0, 1,'h13, 0,0,0,0,0, 0,'h13, 0,0, 0, 1,1);
    // reset, then both requesting: DM, IF, DM
    add(1,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,'h13, 0,0, 0, 1,1);
    add(0,1,'h104,0, 1,0,0,'h2000,0, 1,'hAAAA0001, 0,0,0,0,0, 0,0, 0,0, 1, 1,1);
    add(0,1,'h104,0, 1,0,0,'h2000,0, 1,'hAAAA0001, 1,0,0,'h2000,0, 0,0, 0,0, 1, 1,1);
    add(0,1,'h104,0, 1,0,0,'h2000,0, 1,'hAAAA0001, 0,0,0,0,0, 0,0, 1,'hAAAA0001, 1, 1,1);
    add(0,1,'h104,0, 1,0,0,'h2004,0, 1,'hAAAA0002, 0,0,0,0,0, 0,0, 0,'hAAAA0001, 1, 1,1);
    add(0,1,'h104,0, 1,0,0,'h2004,0, 1,'hAAAA0002, 1,0,0,'h104,0, 0,0, 0,'hAAAA0001, 1, 1,1);
    add(0,1,'h104,0, 1,0,0,'h2004,0, 1,'hAAAA0002, 0,0,0,0,0, 1,'hAAAA0002, 0,'hAAAA0001, 1, 1,1);
    add(0,1,'h108,0, 1,0,0,'h2004,0, 1,'hAAAA0003, 0,0,0,0,0, 0,'hAAAA0002, 0,'hAAAA0001, 1, 1,1);
    add(0,1,'h108,0, 1,0,0,'h2004,0, 1,'hAAAA0003, 1,0,0,'h2004,0, 0,'hAAAA0002, 0,'hAAAA0001, 1, 1,1);
    add(0,1,'h108,0, 1,0,0,'h2004,0, 1,'hAAAA0003, 0,0,0,0,0, 0,'hAAAA0002, 1,'hAAAA0003, 1, 1,1);
    add(0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,'hAAAA0002, 0,'hAAAA0003, 0, 1,1);
    // store with three wait states; IF waits out the ACK cycle
    add(0,0,0,0, 1,1,'h3,'h3000,'hDEADBEEF, 0,0, 0,0,0,0,0, 0,'hAAAA0002, 0,'hAAAA0003, 1, 1,1);
    add(0,0,0,0, 1,1,'h3,'h3000,'hDEADBEEF, 0,0, 1,1,'h3,'h3000,'hDEADBEEF, 0,'hAAAA0002, 0,'hAAAA0003, 1, 1,1);
    add(0,0,0,0, 1,1,'h3,'h3000,'hDEADBEEF, 0,0, 1,1,'h3,'h3000,'hDEADBEEF, 0,'hAAAA0002, 0,'hAAAA0003, 1, 1,1);
    add(0,0,0,0, 1,1,'h3,'h3000,'hDEADBEEF, 0,0, 1,1,'h3,'h3000,'hDEADBEEF, 0,'hAAAA0002, 0,'hAAAA0003, 1, 1,1);
    add(0,0,0,0, 1,1,'h3,'h3000,'hDEADBEEF, 1,'h5555, 1,1,'h3,'h3000,'hDEADBEEF, 0,'hAAAA0002, 0,'hAAAA0003, 1, 1,1);
    add(0,1,'h400,0, 1,1,'h3,'h3000,'hDEADBEEF, 0,0, 0,0,0,0,0, 0,'hAAAA0002, 1,0, 1, 1,0);
    add(0,1,'h400,0, 0,0,0,0,0, 1,'h77, 0,0,0,0,0, 0,'hAAAA0002, 0,0, 1, 1,0);
    add(0,1,'h400,0, 0,0,0,0,0, 1,'h77, 1,0,0,'h400,0, 0,'hAAAA0002, 0,0, 1, 1,0);
    add(0,1,'h400,0, 0,0,0,0,0, 1,'h77, 0,0,0,0,0, 1,'h77, 0,0, 0, 1,0);
    add(0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,'h77, 0,0, 0, 1,0);
    // fetch flushed during a wait state; then a load; then a flush blocking a grant in IDLE
    add(0,1,'h200,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,'h77, 0,0, 1, 1,0);
    add(0,1,'h200,0, 0,0,0,0,0, 0,0, 1,0,0,'h200,0, 0,'h77, 0,0, 1, 1,0);
    add(0,1,'h200,1, 0,0,0,0,0, 0,0, 1,0,0,'h200,0, 0,'h77, 0,0, 0, 1,0);
    add(0,1,'h200,0, 0,0,0,0,0, 0,0, 1,0,0,'h200,0, 0,'h77, 0,0, 1, 1,0);
    add(0,1,'h200,0, 0,0,0,0,0, 1,'h99, 1,0,0,'h200,0, 0,'h77, 0,0, 1, 1,0);
    add(0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,'h77, 0,0, 0, 1,0);
    add(0,0,0,0, 1,0,0,'h2100,0, 1,'h1234, 0,0,0,0,0, 0,'h77, 0,0, 1, 1,0);
    add(0,0,0,0, 1,0,0,'h2100,0, 1,'h1234, 1,0,0,'h2100,0, 0,'h77, 0,0, 1, 1,0);
    add(0,0,0,0, 1,0,0,'h2100,0, 1,'h1234, 0,0,0,0,0, 0,'h77, 1,'h1234, 0, 1,1);
    add(0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,'h77, 0,'h1234, 0, 1,1);
    add(0,1,'h300,1, 0,0,0,0,0, 1,'hBAD, 0,0,0,0,0, 0,'h77, 0,'h1234, 0, 1,1);
    add(0,0,0,0, 0,0,0,0,0, 1,'hBAD, 0,0,0,0,0, 0,'h77, 0,'h1234, 0, 1,1);
    // reset in the middle of a DM access, then a clean fetch and load
    add(0,0,0,0, 1,0,0,'h2200,0, 0,0, 0,0,0,0,0, 0,'h77, 0,'h1234, 1, 1,1);
    add(1,0,0,0, 1,0,0,'h2200,0, 0,0, 1,0,0,'h2200,0, 0,'h77, 0,'h1234, 1, 1,1);
    add(0,1,'h500,0, 0,0,0,0,0, 1,'h42, 0,0,0,0,0, 0,0, 0,0, 1, 1,1);
    add(0,1,'h500,0, 0,0,0,0,0, 1,'h42, 1,0,0,'h500,0, 0,0, 0,0, 1, 1,1);
    add(0,1,'h500,0, 0,0,0,0,0, 1,'h42, 0,0,0,0,0, 1,'h42, 0,0, 0, 1,1);
    add(0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,'h42, 0,0, 0, 1,1);
    add(0,0,0,0, 1,0,'hF,'h2400,0, 1,'hFEED, 0,0,0,0,0, 0,'h42, 0,0, 1, 1,1);
    add(0,0,0,0, 1,0,'hF,'h2400,0, 1,'hFEED, 1,0,'hF,'h2400,0, 0,'h42, 0,0, 1, 1,1);
    add(0,0,0,0, 1,0,'hF,'h2400,0, 1,'hFEED, 0,0,0,0,0, 0,'h42, 1,'hFEED, 0, 1,1);
    add(0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0, 0,'h42, 0,'hFEED, 0, 1,1);

    drive_idle();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("rst_mreq", -1, mem_req_out, 0);
    chk("rst_mwe", -1, mem_we_out, 0);
    chk("rst_mwm", -1, mem_wmask_out, 0);
    chk("rst_maddr", -1, mem_addr_out, 0);
    chk("rst_mwd", -1, mem_wdata_out, 0);
    chk("rst_iack", -1, if_ack_out, 0);
    chk("rst_ird", -1, if_rdata_out, 0);
    chk("rst_dack", -1, dm_ack_out, 0);
    chk("rst_drd", -1, dm_rdata_out, 0);
    chk("rst_err", -1, err_out, 0);
    chk("rst_stall", -1, stall_out, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk_in);
      rst_in = v.rst; if_req_in = v.ifr; if_addr_in = v.ia; if_flush_in = v.fl;
      dm_req_in = v.dmr; dm_we_in = v.we; dm_wmask_in = v.wm; dm_addr_in = v.da; dm_wdata_in = v.wd;
      mem_ready_in = v.rdy; mem_rdata_in = v.rd;
      #1;
      chk("mreq", i, mem_req_out, v.e_mreq);
      if (v.e_mreq) begin
        chk("mwe", i, mem_we_out, v.e_mwe);
        chk("mwm", i, mem_wmask_out, v.e_mwm);
        chk("maddr", i, mem_addr_out, v.e_maddr);
        if (v.e_mwe) chk("mwd", i, mem_wdata_out, v.e_mwd);
      end
      chk("iack", i, if_ack_out, v.e_iack);
      chk("dack", i, dm_ack_out, v.e_dack);
      chk("err", i, err_out, 0);
      chk("stall", i, stall_out, v.e_stall);
      if (v.chk_i) chk("ird", i, if_rdata_out, v.e_ird);
      if (v.chk_d) chk("drd", i, dm_rdata_out, v.e_drd);
    end

    // DM load that never sees mem_ready_in
    @(negedge clk_in);
    drive_idle();
    dm_req_in  = 1'b1;
    dm_addr_in = 32'h2300;
`ifdef ARB_TIMEOUT_EN
    n   = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk_in);
      #1;
      if (dm_ack_out) got = 1'b1;
      else if (mem_req_out) n++;
    end
    chk("to_ack", 100, got, 1);
    chk("to_len", 100, n, 16);
    chk("to_err", 100, err_out, 1);
    chk("to_drd", 100, dm_rdata_out, 0);
    chk("to_mreq", 100, mem_req_out, 0);
    @(negedge clk_in);
    dm_req_in = 1'b0;
    #1;
    chk("to_err_clr", 101, err_out, 0);
    chk("to_ack_clr", 101, dm_ack_out, 0);
`else
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      #1;
      chk("wait_mreq", 100 + c, mem_req_out, 1);
      chk("wait_dack", 100 + c, dm_ack_out, 0);
      chk("wait_err", 100 + c, err_out, 0);
      if (mem_req_out) n++;
    end
    chk("wait_len", 120, n, 20);
    mem_ready_in = 1'b1;
    mem_rdata_in = 32'hC0DE;
    @(negedge clk_in);
    #1;
    chk("late_dack", 121, dm_ack_out, 1);
    chk("late_err", 121, err_out, 0);
    chk("late_drd", 121, dm_rdata_out, 32'hC0DE);
    dm_req_in    = 1'b0;
    mem_ready_in = 1'b0;
    @(negedge clk_in);
    #1;
    chk("late_dack_clr", 122, dm_ack_out, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
